// File: rtl/btn_toggle_conditioner.sv
// Purpose: turns a raw bouncing push-button into a clean one-cycle toggle pulse T plus a debounced LEVEL.
// Latency: T and LEVEL rise DEBOUNCE_CYCLES+2 edges after the first pressed sample; LEVEL falls the same distance after release.
// Backpressure: none. The input is sampled every cycle and T is a fire-and-forget strobe.
// Optional build macro HOLD_REPEAT_EN adds auto-repeat pulses while the button stays held.

module btn_toggle_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b0,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic T,
  output logic LEVEL
);

  // Elaboration-time parameter sanity; the hold parameters are checked even
  // when the repeat feature is compiled out so a bad value is caught early.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  // Last count value of a debounce window: reaching it with a stable input
  // on the following edge commits the transition.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic             sync_meta;
  logic             sync_out;
  logic             btn_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             t_nxt;
  logic             level_nxt;

`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  // hold_cnt counts cycles spent in PRESSED; rep_phase marks that the first
  // (long) hold delay has elapsed and the shorter repeat period now applies.
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  logic             rep_phase;
  logic             rep_phase_nxt;
`endif

  // Two-flop synchronizer with polarity correction ahead of the first flop,
  // so reset leaves both stages at "not pressed" regardless of polarity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= BTN ^ BTN_ACTIVE_LOW;
      sync_out  <= sync_meta;
    end
  end

  assign btn_s = sync_out;

  // State, counters and the registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      T     <= 1'b0;
      LEVEL <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      T     <= t_nxt;
      LEVEL <= level_nxt;
    end
  end

`ifdef HOLD_REPEAT_EN
  // Hold/repeat timer state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_nxt;
      rep_phase <= rep_phase_nxt;
    end
  end
`endif

  // Debounce FSM: next state, debounce counter and toggle pulse request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    t_nxt     = 1'b0;
`ifdef HOLD_REPEAT_EN
    // Cleared everywhere except while sitting in PRESSED, so any exit or
    // re-entry restarts the long hold phase.
    hold_cnt_nxt  = '0;
    rep_phase_nxt = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (btn_s) begin
          state_nxt = S_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end

      S_PRESS_WAIT: begin
        if (!btn_s) begin
          // Bounce during the press window: drop it silently.
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = S_PRESSED;
          cnt_nxt   = '0;
          t_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_PRESSED: begin
        if (!btn_s) begin
          state_nxt = S_RELEASE_WAIT;
          cnt_nxt   = '0;
        end else begin
`ifdef HOLD_REPEAT_EN
          if (!rep_phase) begin
            if (hold_cnt == HOLD_LAST) begin
              t_nxt         = 1'b1;
              hold_cnt_nxt  = '0;
              rep_phase_nxt = 1'b1;
            end else begin
              hold_cnt_nxt  = hold_cnt + CNT_W'(1);
              rep_phase_nxt = 1'b0;
            end
          end else begin
            rep_phase_nxt = 1'b1;
            if (hold_cnt == REP_LAST) begin
              t_nxt        = 1'b1;
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
          end
`endif
        end
      end

      S_RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: back to PRESSED without a new pulse.
          state_nxt = S_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Downstream toggle stage needs a gap between strobes; this only bites
    // for degenerate hold/repeat settings of 1 cycle.
    t_nxt = t_nxt & ~T;

    // Debounced level is high in both states that mean "accepted press".
    level_nxt = (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE_WAIT);
  end

  // The toggle strobe is always a single cycle wide.
  a_t_single_cycle : assert property (@(posedge CLK) disable iff (RST) T |=> !T);

endmodule

// File: tb/tb_btn_toggle_conditioner.sv
// Bench for btn_toggle_conditioner: active-high and active-low instances,
// T pulses checked against a queue of expected edge numbers, LEVEL checked per cycle.
// Build with +define+HOLD_REPEAT_EN to exercise the auto-repeat variant.

module tb_btn_toggle_conditioner;

  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 4;
`ifdef HOLD_REPEAT_EN
  localparam int HOLD40_PULSES = 8;
`else
  localparam int HOLD40_PULSES = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn_n = 1'b1;
  logic t, level, t_al, level_al;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int t_seen = 0;
  int t_seen_al = 0;
  int q[$];
  int q_al[$];

  btn_toggle_conditioner #(
    .DEBOUNCE_CYCLES(D), .CNT_W(16), .BTN_ACTIVE_LOW(1'b0),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .CLK(clk), .RST(rst), .BTN(btn), .T(t), .LEVEL(level)
  );

  btn_toggle_conditioner #(
    .DEBOUNCE_CYCLES(D), .CNT_W(16), .BTN_ACTIVE_LOW(1'b1),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut_al (
    .CLK(clk), .RST(rst), .BTN(btn_n), .T(t_al), .LEVEL(level_al)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected T pulses: the press acceptance edge (if any) plus, in the
  // repeat build, pulses at p+H, p+H+R, ... while still in PRESSED.
  function automatic void push_press(input bit inst, input bit entry, input int p, input int leave);
    if (entry) begin
      if (inst) q_al.push_back(p); else q.push_back(p);
    end
`ifdef HOLD_REPEAT_EN
    for (int e = p + H; e < leave; e += R) begin
      if (inst) q_al.push_back(e); else q.push_back(e);
    end
`endif
  endfunction

  // Scoreboard for the active-high instance.
  always @(negedge clk) begin
    if (t === 1'b1) begin
      t_seen++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL t_unexpected: pulse at cyc=%0d, expected none", cyc);
      end else begin
        int e;
        e = q.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL t_timing: pulse at cyc=%0d, expected cyc=%0d", cyc, e);
        end
      end
    end else if (q.size() > 0 && cyc > q[0]) begin
      total++;
      bad++;
      $display("FAIL t_missing: no pulse by cyc=%0d, expected at cyc=%0d", cyc, q[0]);
      void'(q.pop_front());
    end
  end

  // Scoreboard for the active-low instance.
  always @(negedge clk) begin
    if (t_al === 1'b1) begin
      t_seen_al++;
      total++;
      if (q_al.size() == 0) begin
        bad++;
        $display("FAIL t_al_unexpected: pulse at cyc=%0d, expected none", cyc);
      end else begin
        int e;
        e = q_al.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL t_al_timing: pulse at cyc=%0d, expected cyc=%0d", cyc, e);
        end
      end
    end else if (q_al.size() > 0 && cyc > q_al[0]) begin
      total++;
      bad++;
      $display("FAIL t_al_missing: no pulse by cyc=%0d, expected at cyc=%0d", cyc, q_al[0]);
      void'(q_al.pop_front());
    end
  end

  task automatic run_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_level(input string name, input logic got, input logic exp);
    // kept tiny on purpose: callers name the scenario
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: LEVEL=%b at cyc=%0d, expected %b", name, got, cyc, exp);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (q.size() != 0 || q_al.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: %0d/%0d expected pulses never seen, expected 0", name, q.size(), q_al.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; btn_n = 1'b1;
    repeat (3) @(negedge clk);
    total += 4;
    if (t !== 1'b0)        begin bad++; $display("FAIL reset_t: T=%b, expected 0", t); end
    if (level !== 1'b0)    begin bad++; $display("FAIL reset_level: LEVEL=%b, expected 0", level); end
    if (t_al !== 1'b0)     begin bad++; $display("FAIL reset_t_al: T=%b, expected 0", t_al); end
    if (level_al !== 1'b0) begin bad++; $display("FAIL reset_level_al: LEVEL=%b, expected 0", level_al); end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int k;
    repeat (2) @(negedge clk);
    k = cyc + 1;
    push_press(0, 1, k + 6, k + 22);
    for (int c = k - 1; c <= k + 30; c++) begin
      run_to(c);
      btn = (c + 1 >= k) && (c + 1 <= k + 19);
      check_level("clean_level", level, (c >= k + 6) && (c <= k + 25));
    end
    check_drained("clean");
  endtask

  task automatic test_press_bounce();
    int s;
    int pat[6] = '{1, 1, 0, 1, 1, 0};
    s = t_seen;
    foreach (pat[i]) begin
      btn = pat[i][0];
      @(negedge clk);
      check_level("bounce_level", level, 1'b0);
    end
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check_level("bounce_level_end", level, 1'b0);
    total++;
    if (t_seen != s) begin
      bad++;
      $display("FAIL bounce_no_t: saw %0d pulses, expected 0", t_seen - s);
    end
  endtask

  task automatic test_release_bounce();
    int k, s;
    repeat (2) @(negedge clk);
    s = t_seen;
    k = cyc + 1;
    push_press(0, 1, k + 6, k + 13);
    push_press(0, 0, k + 15, k + 19);
    for (int c = k - 1; c <= k + 28; c++) begin
      run_to(c);
      btn = ((c + 1 >= k) && (c + 1 <= k + 10)) || ((c + 1 >= k + 13) && (c + 1 <= k + 16));
      check_level("relbounce_level", level, (c >= k + 6) && (c <= k + 22));
    end
    check_drained("relbounce");
    total++;
    if (t_seen - s != 1) begin
      bad++;
      $display("FAIL relbounce_count: saw %0d pulses, expected 1", t_seen - s);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    repeat (2) @(negedge clk);
    k = cyc + 1;
    // Reset edges at k+5 (mid-debounce) and k+13 (right after the T at k+12).
    push_press(0, 1, k + 12, k + 13);
    push_press(0, 1, k + 20, k + 23);
    for (int c = k - 1; c <= k + 32; c++) begin
      run_to(c);
      btn = (c + 1 >= k) && (c + 1 <= k + 20);
      rst = (c == k + 4) || (c == k + 12);
      if (c == k + 5 || c == k + 13) begin
        total++;
        if (t !== 1'b0) begin
          bad++;
          $display("FAIL resetmid_t: T=%b at cyc=%0d, expected 0", t, cyc);
        end
      end
      check_level("resetmid_level", level, (c == k + 12) || ((c >= k + 20) && (c <= k + 26)));
    end
    rst = 1'b0;
    check_drained("resetmid");
  endtask

  task automatic test_active_low();
    int k, s;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s = t_seen_al;
    repeat (50) @(negedge clk);
    check_level("al_idle_level", level_al, 1'b0);
    total++;
    if (t_seen_al != s) begin
      bad++;
      $display("FAIL al_idle_t: saw %0d pulses, expected 0", t_seen_al - s);
    end
    k = cyc + 1;
    push_press(1, 1, k + 6, k + 22);
    for (int c = k - 1; c <= k + 30; c++) begin
      run_to(c);
      btn_n = !((c + 1 >= k) && (c + 1 <= k + 19));
      check_level("al_level", level_al, (c >= k + 6) && (c <= k + 25));
    end
    btn_n = 1'b1;
    check_drained("al");
  endtask

  task automatic test_hold();
    int k, s;
    repeat (2) @(negedge clk);
    s = t_seen;
    k = cyc + 1;
    push_press(0, 1, k + 6, k + 42);
    for (int c = k - 1; c <= k + 50; c++) begin
      run_to(c);
      btn = (c + 1 >= k) && (c + 1 <= k + 39);
      check_level("hold_level", level, (c >= k + 6) && (c <= k + 45));
    end
    check_drained("hold");
    total++;
    if (t_seen - s != HOLD40_PULSES) begin
      bad++;
      $display("FAIL hold_count: saw %0d pulses, expected %0d", t_seen - s, HOLD40_PULSES);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    repeat (2) @(negedge clk);
    k = cyc + 1;
    // D samples (rejected), then D+1 samples (accepted), then a second press
    // right after the release debounce completes.
    push_press(0, 1, k + 18, k + 19);
    push_press(0, 1, k + 28, k + 29);
    for (int c = k - 1; c <= k + 40; c++) begin
      run_to(c);
      btn = ((c + 1 >= k) && (c + 1 <= k + 3)) ||
            ((c + 1 >= k + 12) && (c + 1 <= k + 16)) ||
            ((c + 1 >= k + 22) && (c + 1 <= k + 26));
      check_level("b2b_level", level, ((c >= k + 18) && (c <= k + 22)) || ((c >= k + 28) && (c <= k + 32)));
    end
    check_drained("b2b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid();
    test_active_low();
    test_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
